gaussian_conv_engine: RTL and testbench

// - Consumer of Gaussian kernel coefficients: loads a SIZE x SIZE fixed-point kernel, then

---
 rtl/gaussian_conv_engine.sv | 270 +++++++++++++++++++++++++++
 tb/tb_gaussian_conv_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_conv_engine.sv
// gaussian_conv_engine
//   Loads a SIZE x SIZE unsigned Q2.14 kernel (row-major, index 0 = top-left),
//   then convolves one raster frame with it. Only fully covered ("valid")
//   windows produce output: (IMG_WIDTH-SIZE+1) x (IMG_HEIGHT-SIZE+1) pixels.
//   Pipeline: window capture -> SIZE*SIZE multiplies -> adder tree + round.
//   Latency is 3 cycles from accepting the window-completing pixel.
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   start              1-cycle pulse, honoured only in IDLE
//   coef_valid/_data   coefficient stream, coef_ready high only in LOAD
//   pix_valid/_data    pixel stream, pix_ready high in RUN when not stalled
//   out_valid/_data    filtered pixel stream, out_ready from downstream
//   busy               high in LOAD, RUN, DRAIN
//   done               1-cycle pulse after the last output of a frame is taken
//   sat_flag           sticky saturation indicator
// Configuration
//   GCONV_SAT_EN defined: results above 2^PIX_W-1 clamp and set sat_flag.
//   GCONV_SAT_EN undefined: low PIX_W bits of the rounded result, sat_flag = 0.
module gaussian_conv_engine #(
    parameter int SIZE       = 5,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 8,
    parameter int COEF_W     = 16,
    parameter int COEF_FRAC  = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              coef_valid,
    input  logic [COEF_W-1:0] coef_data,
    output logic              coef_ready,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    output logic              out_valid,
    output logic [PIX_W-1:0]  out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              sat_flag
);
    localparam int NTAP   = SIZE * SIZE;
    localparam int PROD_W = PIX_W + COEF_W;
    localparam int SUM_W  = PROD_W + $clog2(NTAP);
    localparam int RND_W  = SUM_W - COEF_FRAC;
    localparam int IDX_W  = $clog2(NTAP);
    localparam int COL_W  = $clog2(IMG_WIDTH);
    localparam int ROW_W  = $clog2(IMG_HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    coef_idx_q, coef_idx_d;
    logic [COEF_W-1:0]   kernel_q [NTAP];
    logic [COEF_W-1:0]   kernel_d [NTAP];
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [PIX_W-1:0]    win_q [SIZE][SIZE];
    logic [PIX_W-1:0]    win_d [SIZE][SIZE];
    logic                s1_valid_q, s1_valid_d;
    logic [PROD_W-1:0]   prod_q [NTAP];
    logic [PROD_W-1:0]   prod_d [NTAP];
    logic                s2_valid_q, s2_valid_d;
    logic                out_valid_q, out_valid_d;
    logic [PIX_W-1:0]    out_data_q, out_data_d;
    logic                done_q, done_d;
    logic [PIX_W-1:0]    lb_q [SIZE-1][IMG_WIDTH];
    logic [PIX_W-1:0]    col_vec [SIZE];
    logic                advance, pix_accept, last_col, last_row, win_full;
    logic [SUM_W-1:0]    sum, rnd_sum;
    logic [PIX_W-1:0]    result;
`ifdef GCONV_SAT_EN
    logic                sat_q, sat_d, result_sat;
    logic [RND_W-1:0]    rounded;
`endif

    assign advance    = !out_valid_q || out_ready;
    assign coef_ready = (state_q == S_LOAD);
    assign pix_ready  = (state_q == S_RUN) && advance;
    assign pix_accept = pix_valid && pix_ready;
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign done       = done_q;
    assign last_col   = (col_q == COL_W'(IMG_WIDTH - 1));
    assign last_row   = (row_q == ROW_W'(IMG_HEIGHT - 1));
    assign win_full   = (col_q >= COL_W'(SIZE - 1)) && (row_q >= ROW_W'(SIZE - 1));
`ifdef GCONV_SAT_EN
    assign sat_flag   = sat_q;
`else
    assign sat_flag   = 1'b0;
`endif

    // New window column: bottom entry is the incoming pixel, above it the
    // same column from the previous SIZE-1 lines (lb_q[0] = line above).
    always_comb begin
        col_vec[SIZE-1] = pix_data;
        for (int unsigned k = 0; k < SIZE - 1; k++) begin
            col_vec[SIZE-2-k] = lb_q[k][col_q];
        end
    end

    always_comb begin
        sum = '0;
        for (int unsigned t = 0; t < NTAP; t++) begin
            sum = sum + SUM_W'(prod_q[t]);
        end
        rnd_sum = sum + SUM_W'(2 ** (COEF_FRAC - 1));
`ifdef GCONV_SAT_EN
        rounded    = RND_W'(rnd_sum >> COEF_FRAC);
        result_sat = (rounded > RND_W'({PIX_W{1'b1}}));
        result     = result_sat ? '1 : rounded[PIX_W-1:0];
`else
        result     = PIX_W'(rnd_sum >> COEF_FRAC);
`endif
    end

    always_comb begin
        state_d     = state_q;
        coef_idx_d  = coef_idx_q;
        kernel_d    = kernel_q;
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        s1_valid_d  = s1_valid_q;
        prod_d      = prod_q;
        s2_valid_d  = s2_valid_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
`ifdef GCONV_SAT_EN
        sat_d       = sat_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    coef_idx_d = '0;
                    col_d      = '0;
                    row_d      = '0;
`ifdef GCONV_SAT_EN
                    sat_d      = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (coef_valid) begin
                    kernel_d[coef_idx_q] = coef_data;
                    if (coef_idx_q == IDX_W'(NTAP - 1)) begin
                        state_d    = S_RUN;
                        coef_idx_d = '0;
                    end else begin
                        coef_idx_d = coef_idx_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (pix_accept && last_col && last_row) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The final pixel of a frame always completes a window, so the
                // frame ends when the output is taken with nothing behind it.
                if (out_valid_q && out_ready && !s1_valid_q && !s2_valid_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pix_accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            for (int unsigned i = 0; i < SIZE; i++) begin
                for (int unsigned j = 0; j < SIZE - 1; j++) begin
                    win_d[i][j] = win_q[i][j+1];
                end
                win_d[i][SIZE-1] = col_vec[i];
            end
        end

        if (advance) begin
            s1_valid_d = pix_accept && win_full;
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                for (int unsigned i = 0; i < SIZE; i++) begin
                    for (int unsigned j = 0; j < SIZE; j++) begin
                        prod_d[i*SIZE+j] = PROD_W'(win_q[i][j]) * PROD_W'(kernel_q[i*SIZE+j]);
                    end
                end
            end
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                out_data_d = result;
`ifdef GCONV_SAT_EN
                if (result_sat) begin
                    sat_d = 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            coef_idx_q  <= '0;
            col_q       <= '0;
            row_q       <= '0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
`ifdef GCONV_SAT_EN
            sat_q       <= 1'b0;
`endif
            for (int unsigned t = 0; t < NTAP; t++) begin
                kernel_q[t] <= '0;
                prod_q[t]   <= '0;
            end
            for (int unsigned i = 0; i < SIZE; i++) begin
                for (int unsigned j = 0; j < SIZE; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            coef_idx_q  <= coef_idx_d;
            col_q       <= col_d;
            row_q       <= row_d;
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
`ifdef GCONV_SAT_EN
            sat_q       <= sat_d;
`endif
            kernel_q    <= kernel_d;
            prod_q      <= prod_d;
            win_q       <= win_d;
        end
    end

    // Line storage is not reset: a line is always rewritten before any window
    // that reaches an output reads it.
    always_ff @(posedge clk) begin
        if (pix_accept) begin
            lb_q[0][col_q] <= pix_data;
            for (int unsigned k = 1; k < SIZE - 1; k++) begin
                lb_q[k][col_q] <= lb_q[k-1][col_q];
            end
        end
    end

endmodule

// File: tb/tb_gaussian_conv_engine.sv
module tb_gaussian_conv_engine;
    localparam int SIZE   = 5;
    localparam int W      = 8;
    localparam int H      = 6;
    localparam int PIX_W  = 8;
    localparam int COEF_W = 16;
    localparam int NOUT   = (W - SIZE + 1) * (H - SIZE + 1);
`ifdef GCONV_SAT_EN
    localparam int SAT_OUT = 255;
    localparam bit SAT_SET = 1'b1;
`else
    localparam int SAT_OUT = 231;
    localparam bit SAT_SET = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              coef_valid;
    logic [COEF_W-1:0] coef_data;
    logic              coef_ready;
    logic              pix_valid;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_ready;
    logic              out_valid;
    logic [PIX_W-1:0]  out_data;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              sat_flag;

    int checks = 0;
    int errors = 0;

    logic [7:0] got[$];
    int done_cnt, done_at, lat, ready_viol, stall_viol;
    bit timed_out;

    typedef struct packed {
        logic [3:0]  kmode;
        logic [3:0]  imode;
        logic        rnd;
        logic        exp_sat;
        logic [63:0] exp_out;
    } vec_t;

    vec_t vecs [6];

    gaussian_conv_engine #(
        .SIZE      (SIZE),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .PIX_W     (PIX_W),
        .COEF_W    (COEF_W),
        .COEF_FRAC (14)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .coef_valid(coef_valid),
        .coef_data (coef_data),
        .coef_ready(coef_ready),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // 0 identity, 1 box 655, 2 all 1.0, 3 top-left 1.0, 4 centre 0.5
    function automatic logic [15:0] coef_of(input int k, input int idx);
        case (k)
            0: return (idx == 12) ? 16'd16384 : 16'd0;
            1: return 16'd655;
            2: return 16'd16384;
            3: return (idx == 0) ? 16'd16384 : 16'd0;
            default: return (idx == 12) ? 16'd8192 : 16'd0;
        endcase
    endfunction

    // 0 ramp r*8+c, 1 constant 100, 2 constant 255
    function automatic logic [7:0] pix_of(input int im, input int r, input int c);
        case (im)
            0: return 8'(r * 8 + c);
            1: return 8'd100;
            default: return 8'd255;
        endcase
    endfunction

    function automatic vec_t mk(input int k, input int im, input bit r,
                                input int o0, input int o1, input int o2, input int o3,
                                input int o4, input int o5, input int o6, input int o7,
                                input bit s);
        vec_t v;
        v.kmode   = 4'(k);
        v.imode   = 4'(im);
        v.rnd     = r;
        v.exp_sat = s;
        v.exp_out = {8'(o7), 8'(o6), 8'(o5), 8'(o4), 8'(o3), 8'(o2), 8'(o1), 8'(o0)};
        return v;
    endfunction

    task automatic run_frame(input int kmode, input int imode, input bit rnd,
                             input int abort_after, input bit poke_start);
        int ci, pi, cyc, acc_cyc, first_cyc, post;
        bit prev_stall, poked;
        logic [7:0] prev_data;
        got.delete();
        done_cnt = 0; done_at = -1; lat = -1; ready_viol = 0; stall_viol = 0; timed_out = 1'b0;
        ci = 0; pi = 0; cyc = 0; acc_cyc = -1; first_cyc = -1; post = 0;
        prev_stall = 1'b0; poked = 1'b0; prev_data = '0;
        @(negedge clk);
        start = 1'b1; coef_valid = 1'b0; pix_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (1) begin
            coef_valid = (ci < SIZE * SIZE);
            coef_data  = coef_of(kmode, ci);
            pix_valid  = (pi < W * H);
            pix_data   = pix_of(imode, pi / W, pi % W);
            out_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start      = 1'b0;
            if (poke_start && !poked && pi == 10) begin
                start = 1'b1;
                poked = 1'b1;
            end
            #1;
            if (done) begin
                done_cnt++;
                done_at = got.size();
            end
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (prev_stall && (!out_valid || out_data !== prev_data)) stall_viol++;
            if (out_valid && !out_ready && pix_ready) ready_viol++;
            if (coef_valid && coef_ready) ci++;
            if (pix_valid && pix_ready) begin
                if (pi == 4 * W + 4) acc_cyc = cyc;
                pi++;
            end
            if (out_valid && out_ready) got.push_back(out_data);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (abort_after >= 0 && pi >= abort_after) break;
            if (done_cnt > 0) post++;
            if (post > 3) break;
            if (cyc >= 2000) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        if (acc_cyc >= 0 && first_cyc >= 0) lat = first_cyc - acc_cyc;
        start = 1'b0; coef_valid = 1'b0; pix_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic check_frame(input string tag, input vec_t v);
        check({tag, " timeout"}, 32'(timed_out), 32'd0);
        check({tag, " out_count"}, got.size(), NOUT);
        for (int i = 0; i < NOUT; i++) begin
            if (i < got.size())
                check($sformatf("%s out%0d", tag, i), 32'(got[i]), 32'(v.exp_out[i*8 +: 8]));
            else
                check($sformatf("%s out%0d missing", tag, i), 32'd1, 32'd0);
        end
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " done_after_outputs"}, done_at, NOUT);
        check({tag, " sat_flag"}, 32'(sat_flag), 32'(v.exp_sat));
        check({tag, " busy_after"}, 32'(busy), 32'd0);
        if (v.rnd) begin
            check({tag, " pix_ready_while_stalled"}, ready_viol, 0);
            check({tag, " output_held_while_stalled"}, stall_viol, 0);
        end else begin
            check({tag, " latency"}, lat, 3);
        end
    endtask

    initial begin
        vecs[0] = mk(0, 0, 1'b0, 18, 19, 20, 21, 26, 27, 28, 29, 1'b0);
        vecs[1] = mk(1, 1, 1'b0, 100, 100, 100, 100, 100, 100, 100, 100, 1'b0);
        vecs[2] = mk(2, 2, 1'b0, SAT_OUT, SAT_OUT, SAT_OUT, SAT_OUT,
                     SAT_OUT, SAT_OUT, SAT_OUT, SAT_OUT, SAT_SET);
        vecs[3] = mk(0, 0, 1'b1, 18, 19, 20, 21, 26, 27, 28, 29, 1'b0);
        vecs[4] = mk(3, 0, 1'b0, 0, 1, 2, 3, 8, 9, 10, 11, 1'b0);
        vecs[5] = mk(4, 0, 1'b0, 9, 10, 10, 11, 13, 14, 14, 15, 1'b0);

        reset = 1'b1; start = 1'b0; coef_valid = 1'b0; coef_data = '0;
        pix_valid = 1'b0; pix_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset out_valid", 32'(out_valid), 0);
        check("reset out_data", 32'(out_data), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset coef_ready", 32'(coef_ready), 0);
        check("reset pix_ready", 32'(pix_ready), 0);
        check("reset sat_flag", 32'(sat_flag), 0);
        reset = 1'b0;

        // Coefficients offered while idle must be refused.
        @(negedge clk);
        coef_valid = 1'b1; coef_data = 16'hFFFF;
        repeat (3) begin
            @(negedge clk);
            check("idle coef_ready", 32'(coef_ready), 0);
            check("idle busy", 32'(busy), 0);
        end
        coef_valid = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_frame(int'(vecs[v].kmode), int'(vecs[v].imode), vecs[v].rnd, -1, 1'b0);
            check_frame($sformatf("vec%0d", v), vecs[v]);
        end

        // start pulse during RUN must not disturb the frame.
        run_frame(0, 0, 1'b0, -1, 1'b1);
        check_frame("start_in_run", vecs[0]);

        // Reset in the middle of a frame.
        run_frame(0, 0, 1'b0, 20, 1'b0);
        check("mid busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check("midreset out_valid", 32'(out_valid), 0);
        check("midreset out_data", 32'(out_data), 0);
        check("midreset busy", 32'(busy), 0);
        check("midreset pix_ready", 32'(pix_ready), 0);
        check("midreset coef_ready", 32'(coef_ready), 0);
        check("midreset done", 32'(done), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("postreset no done", 32'(done), 0);
            check("postreset idle", 32'(busy), 0);
        end
        run_frame(0, 0, 1'b0, -1, 1'b0);
        check_frame("after_reset", vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
